// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480 VGA receive timing constants, lock states and counter helpers
package vga_pkg;

  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_BACK      = 48;
  localparam int VGA_H_START     = VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_H_ACTIVE    = 640;
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_BACK      = 33;
  localparam int VGA_V_START     = VGA_V_SYNC + VGA_V_BACK;
  localparam int VGA_V_ACTIVE    = 480;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_LOCK_FRAMES = 2;

  localparam int RGB_W = 6;
  localparam int CNT_W = 10;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   meas_t;

  localparam cnt_t CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

  function automatic cnt_t sat_inc(cnt_t v);
    return (v == CNT_MAX) ? CNT_MAX : v + cnt_t'(1);
  endfunction

  // Measurements are one wider than the counters; clamp when reporting them.
  function automatic cnt_t sat_meas(meas_t v);
    return v[CNT_W] ? CNT_MAX : v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/vga_sync_receiver_if.sv
// rtl/vga_sync_receiver_if.sv - VGA source signals in, recovered pixel stream out
interface vga_sync_receiver_if;
  import vga_pkg::*;

  logic             hs_in;
  logic             vs_in;
  logic [RGB_W-1:0] rgb_in;
  logic             pix_valid;
  logic [RGB_W-1:0] pix_rgb;
  cnt_t             x;
  cnt_t             y;
  logic             frame_start;

  modport master (
    output hs_in, vs_in, rgb_in,
    input  pix_valid, pix_rgb, x, y, frame_start
  );

  modport slave (
    input  hs_in, vs_in, rgb_in,
    output pix_valid, pix_rgb, x, y, frame_start
  );

endinterface

// File: rtl/vga_lock_fsm.sv
// rtl/vga_lock_fsm.sv - timing lock state machine fed by line/frame measurements
module vga_lock_fsm
  import vga_pkg::*;
#(
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  hs_edge,
  input  logic  frame_edge,
  input  meas_t h_total,
  input  meas_t v_total,
  input  logic  h_sat,
  output logic  locked,
  output logic  lock_next
);

  lock_state_t state, state_nxt;
  logic [3:0]  match_cnt, match_nxt;
  logic        h_ok, v_ok;

  assign h_ok = (h_total == meas_t'(H_TOTAL));
  assign v_ok = (v_total == meas_t'(V_TOTAL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      match_cnt <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
    end
  end

  // The edge that moves SEARCH->VERIFY is never checked, so every check in
  // VERIFY sees a line/frame that started at or after that boundary.
  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    case (state)
      SEARCH: begin
        match_nxt = '0;
        if (frame_edge) state_nxt = VERIFY;
      end
      VERIFY: begin
        if (hs_edge && !h_ok) begin
          state_nxt = SEARCH;
          match_nxt = '0;
        end else if (frame_edge) begin
          if (!v_ok) begin
            state_nxt = SEARCH;
            match_nxt = '0;
          end else if (match_cnt + 4'd1 == 4'(LOCK_FRAMES)) begin
            state_nxt = LOCKED;
            match_nxt = '0;
          end else begin
            match_nxt = match_cnt + 4'd1;
          end
        end
      end
      LOCKED: begin
        if ((hs_edge && !h_ok) || (frame_edge && !v_ok) || h_sat) begin
          state_nxt = SEARCH;
          match_nxt = '0;
        end
      end
      default: begin
        state_nxt = SEARCH;
        match_nxt = '0;
      end
    endcase
  end

  always_comb begin
    locked    = (state == LOCKED);
    lock_next = (state_nxt == LOCKED);
  end

endmodule

// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - VGA receiver: sync measurement, lock and x/y/colour recovery
module vga_sync_receiver
  import vga_pkg::*;
#(
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_START     = VGA_H_START,
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_START     = VGA_V_START,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic                clk,
  input  logic                rst_n,
  vga_sync_receiver_if.slave  vga,
  output logic                locked,
  output cnt_t                h_total,
  output cnt_t                v_total
);

  logic             hs_q, hs_prev, vs_q, vs_prev;
  logic [RGB_W-1:0] rgb_q;
  logic             hs_edge, vs_edge, frame_edge, vs_pend;
  cnt_t             h_cnt_r, v_cnt_r, h_cnt, v_cnt;
  meas_t            h_meas, v_meas;
  logic             h_sat, lock_next, in_win;
  logic             pix_valid_r;
  cnt_t             x_r, y_r;
  logic [RGB_W-1:0] rgb_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q    <= ~SYNC_POL;
      hs_prev <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      vs_prev <= ~SYNC_POL;
      rgb_q   <= '0;
    end else begin
      hs_q    <= vga.hs_in;
      hs_prev <= hs_q;
      vs_q    <= vga.vs_in;
      vs_prev <= vs_q;
      rgb_q   <= vga.rgb_in;
    end
  end

  assign hs_edge    = (hs_q == SYNC_POL) && (hs_prev != SYNC_POL);
  assign vs_edge    = (vs_q == SYNC_POL) && (vs_prev != SYNC_POL);
  assign frame_edge = hs_edge && (vs_pend || vs_edge);

  // h_cnt/v_cnt are the positions of the sample currently in rgb_q; the
  // registered copies carry them to the next cycle.
  assign h_cnt  = hs_edge ? '0 : sat_inc(h_cnt_r);
  assign v_cnt  = frame_edge ? '0 : (hs_edge ? sat_inc(v_cnt_r) : v_cnt_r);
  assign h_meas = {1'b0, h_cnt_r} + 11'd1;
  assign v_meas = {1'b0, v_cnt_r} + 11'd1;
  assign h_sat  = (h_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
      h_total <= '0;
      v_total <= '0;
      vs_pend <= 1'b0;
    end else begin
      h_cnt_r <= h_cnt;
      v_cnt_r <= v_cnt;
      if (hs_edge)    h_total <= sat_meas(h_meas);
      if (frame_edge) v_total <= sat_meas(v_meas);
      if (frame_edge)   vs_pend <= 1'b0;
      else if (vs_edge) vs_pend <= 1'b1;
    end
  end

  vga_lock_fsm #(
    .H_TOTAL     (H_TOTAL),
    .V_TOTAL     (V_TOTAL),
    .LOCK_FRAMES (LOCK_FRAMES)
  ) u_lock (
    .clk        (clk),
    .rst_n      (rst_n),
    .hs_edge    (hs_edge),
    .frame_edge (frame_edge),
    .h_total    (h_meas),
    .v_total    (v_meas),
    .h_sat      (h_sat),
    .locked     (locked),
    .lock_next  (lock_next)
  );

  assign in_win = ({1'b0, h_cnt} >= meas_t'(H_START))
               && ({1'b0, h_cnt} <  meas_t'(H_START + H_ACTIVE))
               && ({1'b0, v_cnt} >= meas_t'(V_START))
               && ({1'b0, v_cnt} <  meas_t'(V_START + V_ACTIVE));

  // Gated by the next lock state so pix_valid drops in the same cycle as locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_r <= 1'b0;
      x_r         <= '0;
      y_r         <= '0;
      rgb_r       <= '0;
    end else if (lock_next && in_win) begin
      pix_valid_r <= 1'b1;
      x_r         <= h_cnt - cnt_t'(H_START);
      y_r         <= v_cnt - cnt_t'(V_START);
      rgb_r       <= rgb_q;
    end else begin
      pix_valid_r <= 1'b0;
      x_r         <= '0;
      y_r         <= '0;
      rgb_r       <= '0;
    end
  end

  assign vga.pix_valid   = pix_valid_r;
  assign vga.pix_rgb     = rgb_r;
  assign vga.x           = x_r;
  assign vga.y           = y_r;
  assign vga.frame_start = pix_valid_r && (x_r == '0) && (y_r == '0);

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - directed bench: reduced-size timing source driving both sync polarities
module tb_vga_sync_receiver;

  localparam int HT  = 40;
  localparam int HS  = 4;
  localparam int HST = 8;
  localparam int HA  = 24;
  localparam int VT  = 20;
  localparam int VS  = 2;
  localparam int VST = 4;
  localparam int VA  = 12;

  typedef struct {
    bit         act;
    int         x;
    int         y;
    logic [5:0] col;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked1, locked2;
  logic [9:0] h_total1, v_total1, h_total2, v_total2;
  int         total = 0;
  int         bad = 0;

  int   gx = HT - 1;
  int   gy = VT - 1;
  int   frame_no = -1;
  int   line_len = HT;
  int   hs_kill = 0;
  bit   stretch_req = 1'b0;
  pix_t p0, p1, p2;

  vga_sync_receiver_if bus1 ();
  vga_sync_receiver_if bus2 ();

  vga_sync_receiver #(
    .H_TOTAL(HT), .H_START(HST), .H_ACTIVE(HA), .V_TOTAL(VT), .V_START(VST),
    .V_ACTIVE(VA), .SYNC_POL(1'b0), .LOCK_FRAMES(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .vga(bus1),
    .locked(locked1), .h_total(h_total1), .v_total(v_total1)
  );

  vga_sync_receiver #(
    .H_TOTAL(HT), .H_START(HST), .H_ACTIVE(HA), .V_TOTAL(VT), .V_START(VST),
    .V_ACTIVE(VA), .SYNC_POL(1'b1), .LOCK_FRAMES(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .vga(bus2),
    .locked(locked2), .h_total(h_total2), .v_total(v_total2)
  );

  always #5 clk = ~clk;

  // Timing source: updates on the falling edge; p2 is what was driven two negedges ago.
  initial begin
    bit hs_act, vs_act;
    p0 = '{0, 0, 0, 6'h2a};
    p1 = p0;
    p2 = p0;
    bus1.hs_in = 1'b1; bus1.vs_in = 1'b1; bus1.rgb_in = '0;
    bus2.hs_in = 1'b0; bus2.vs_in = 1'b0; bus2.rgb_in = '0;
    forever begin
      @(negedge clk);
      if (gx >= line_len - 1) begin
        gx = 0;
        line_len = stretch_req ? HT + 1 : HT;
        stretch_req = 1'b0;
        if (gy == VT - 1) begin
          gy = 0;
          frame_no++;
        end else begin
          gy++;
        end
      end else begin
        gx++;
      end
      if (hs_kill > 0) hs_kill--;
      p2 = p1;
      p1 = p0;
      p0.act = (gx >= HST) && (gx < HST + HA) && (gy >= VST) && (gy < VST + VA);
      p0.x   = p0.act ? gx - HST : 0;
      p0.y   = p0.act ? gy - VST : 0;
      p0.col = p0.act ? 6'(gx - HST) : 6'h2a;
      hs_act = (gx < HS) && (hs_kill == 0);
      vs_act = (gy < VS);
      bus1.hs_in = !hs_act; bus1.vs_in = !vs_act; bus1.rgb_in = p0.col;
      bus2.hs_in = hs_act;  bus2.vs_in = vs_act;  bus2.rgb_in = p0.col;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pos(input int wy, input int wx);
    for (int i = 0; i < 2000 && !(gy == wy && gx == wx); i++) step();
    total++;
    if (!(gy == wy && gx == wx)) begin
      bad++;
      $display("FAIL wait_pos: at (%0d,%0d) want (%0d,%0d)", gx, gy, wx, wy);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++;
    if ({locked1, locked2} !== 2'b00) begin
      bad++; $display("FAIL reset_locked: got %b%b want 00", locked1, locked2);
    end
    total++;
    if ({h_total1, v_total1, h_total2, v_total2} !== 40'd0) begin
      bad++; $display("FAIL reset_totals: got %0d %0d %0d %0d want 0", h_total1, v_total1, h_total2, v_total2);
    end
    total++;
    if ({bus1.pix_valid, bus1.frame_start, bus1.pix_rgb, bus1.x, bus1.y} !== 28'd0) begin
      bad++; $display("FAIL reset_pix: valid=%b x=%0d y=%0d rgb=%h want 0", bus1.pix_valid, bus1.x, bus1.y, bus1.pix_rgb);
    end
    wait_pos(3, 15);
    rst_n = 1'b1;
  endtask

  task automatic wait_lock(input int base_frame, input string name);
    int n = 0;
    while (!locked1 && n < 4000) begin step(); n++; end
    total++;
    if (locked1 !== 1'b1 || frame_no !== base_frame + 3 || gx !== 2) begin
      bad++;
      $display("FAIL %s: locked=%b frame=%0d gx=%0d want 1 frame=%0d gx=2", name, locked1, frame_no, gx, base_frame + 3);
    end
    total++;
    if (locked2 !== 1'b1) begin
      bad++; $display("FAIL %s_pol1: locked=%b want 1", name, locked2);
    end
  endtask

  task automatic test_lock();
    wait_lock(0, "lock_point");
    total++;
    if (h_total1 !== 10'(HT) || v_total1 !== 10'(VT)) begin
      bad++; $display("FAIL lock_totals: h=%0d v=%0d want %0d %0d", h_total1, v_total1, HT, VT);
    end
    total++;
    if (h_total2 !== 10'(HT) || v_total2 !== 10'(VT)) begin
      bad++; $display("FAIL lock_totals_pol1: h=%0d v=%0d want %0d %0d", h_total2, v_total2, HT, VT);
    end
  endtask

  task automatic test_pixels();
    int nvalid = 0;
    int nfs = 0;
    bit exp_fs;
    wait_pos(0, 0);
    for (int i = 0; i < HT * VT; i++) begin
      step();
      exp_fs = p2.act && p2.x == 0 && p2.y == 0;
      total++;
      if (bus1.pix_valid !== p2.act || bus2.pix_valid !== p2.act) begin
        bad++; $display("FAIL pix_valid: got %b/%b want %b at gx=%0d gy=%0d", bus1.pix_valid, bus2.pix_valid, p2.act, gx, gy);
      end
      total++;
      if (bus1.frame_start !== exp_fs || bus2.frame_start !== exp_fs) begin
        bad++; $display("FAIL frame_start: got %b/%b want %b", bus1.frame_start, bus2.frame_start, exp_fs);
      end
      total++;
      if ({bus1.x, bus1.y, bus1.pix_rgb} !== {10'(p2.x), 10'(p2.y), p2.act ? p2.col : 6'd0}
          || {bus2.x, bus2.y, bus2.pix_rgb} !== {10'(p2.x), 10'(p2.y), p2.act ? p2.col : 6'd0}) begin
        bad++;
        $display("FAIL pix_data: got x=%0d y=%0d rgb=%h want x=%0d y=%0d rgb=%h", bus1.x, bus1.y, bus1.pix_rgb, p2.x, p2.y, p2.act ? p2.col : 6'd0);
      end
      if (bus1.pix_valid) nvalid++;
      if (bus1.frame_start) nfs++;
    end
    total++;
    if (nvalid !== HA * VA) begin
      bad++; $display("FAIL valid_count: got %0d want %0d", nvalid, HA * VA);
    end
    total++;
    if (nfs !== 1) begin
      bad++; $display("FAIL frame_start_count: got %0d want 1", nfs);
    end
  endtask

  task automatic test_stretch();
    int n = 0;
    int f;
    wait_pos(5, 10);
    stretch_req = 1'b1;
    while (locked1 && n < 200) begin step(); n++; end
    total++;
    if (locked1 !== 1'b0 || gy !== 7 || gx !== 2) begin
      bad++; $display("FAIL stretch_drop: locked=%b at gx=%0d gy=%0d want 0 at 2,7", locked1, gx, gy);
    end
    total++;
    if (h_total1 !== 10'd41 || h_total2 !== 10'd41 || locked2 !== 1'b0) begin
      bad++; $display("FAIL stretch_meas: h=%0d/%0d locked2=%b want 41 0", h_total1, h_total2, locked2);
    end
    f = frame_no;
    wait_lock(f, "stretch_relock");
  endtask

  task automatic test_reset_mid();
    int f;
    wait_pos(5, 20);
    total++;
    if (bus1.pix_valid !== 1'b1 || locked1 !== 1'b1) begin
      bad++; $display("FAIL pre_reset: valid=%b locked=%b want 1 1", bus1.pix_valid, locked1);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({locked1, locked2, h_total1, v_total1, h_total2, v_total2} !== 42'd0) begin
      bad++; $display("FAIL async_reset_status: locked=%b%b h=%0d v=%0d want 0", locked1, locked2, h_total1, v_total1);
    end
    total++;
    if ({bus1.pix_valid, bus1.frame_start, bus1.pix_rgb, bus1.x, bus1.y} !== 28'd0
        || {bus2.pix_valid, bus2.pix_rgb, bus2.x, bus2.y} !== 27'd0) begin
      bad++; $display("FAIL async_reset_pix: valid=%b x=%0d y=%0d rgb=%h want 0", bus1.pix_valid, bus1.x, bus1.y, bus1.pix_rgb);
    end
    repeat (3) step();
    rst_n = 1'b1;
    f = frame_no;
    wait_lock(f, "reset_relock");
  endtask

  task automatic test_hsync_loss();
    int n = 0;
    wait_pos(5, 10);
    hs_kill = 1100;
    while (locked1 && n < 1200) begin step(); n++; end
    total++;
    if (locked1 !== 1'b0 || n !== 1015) begin
      bad++; $display("FAIL hsync_loss_drop: locked=%b after %0d want 0 after 1015", locked1, n);
    end
    total++;
    if (bus1.pix_valid !== 1'b0 || bus2.pix_valid !== 1'b0 || locked2 !== 1'b0) begin
      bad++; $display("FAIL hsync_loss_outputs: valid=%b/%b locked2=%b want 0", bus1.pix_valid, bus2.pix_valid, locked2);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pixels();
    test_stretch();
    test_reset_mid();
    test_hsync_loss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
